hitomezashi_pattern_gen: RTL and testbench

//  Parametrised Hitomezashi stitch-pattern pixel shader for the video output path.
//  - Per pixel (i_x, i_y), decides whether the pixel lies on an "on" stitch segment of a square grid.
//  - Outputs the foreground or background RGB, registered.
//  - Both vertical and horizontal seed patterns can scroll, on an internal tick or a mode-selected axis.
//  - Patterns can be reloaded serially at run time.
//  - Sits between the video timing generator (supplies i_x/i_y) and the RGB output mux.

---
 rtl/hitomezashi_pattern_gen.sv | 113 +++++++++++
 tb/tb_hitomezashi_pattern_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hitomezashi_pattern_gen.sv
// Hitomezashi stitch-pattern pixel shader: registered FG/BG colour per pixel, with scrolling and serially reloadable seeds.
// Build macro HITOMEZASHI_LFSR_EN: scroll shifts in a 16-bit LFSR bit instead of rotating the pattern.
module hitomezashi_pattern_gen #(
  parameter int unsigned CELL_LOG2    = 5,
  parameter int unsigned V_LINES_LOG2 = 6,
  parameter int unsigned H_LINES_LOG2 = 5,
  parameter logic [(2**V_LINES_LOG2)-1:0] V_SEED = 64'h5A5A_5A5A_5A5A_5A5A,
  parameter logic [(2**H_LINES_LOG2)-1:0] H_SEED = 32'h0000_0001,
  parameter int unsigned DELAY_COUNT  = 15000000,
  parameter logic [23:0] FG_RGB       = 24'hFFFF00,
  parameter logic [23:0] BG_RGB       = 24'h0000FF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic               i_pix_valid,
  input  logic [1:0]         i_mode,
  input  logic               i_load_valid,
  input  logic               i_load_sel,
  input  logic               i_load_bit,
  output logic [7:0]         o_red,
  output logic [7:0]         o_green,
  output logic [7:0]         o_blue,
  output logic               o_pix_valid
);

  localparam int unsigned V     = 2**V_LINES_LOG2;
  localparam int unsigned H     = 2**H_LINES_LOG2;
  localparam int unsigned CNT_W = (DELAY_COUNT > 1) ? $clog2(DELAY_COUNT) : 1;

  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic [V-1:0]            v_pat, v_nxt;
  logic [H-1:0]            h_pat, h_nxt;
  logic                    v_fill, h_fill;
  logic [V_LINES_LOG2-1:0] vidx;
  logic [H_LINES_LOG2-1:0] hidx;
  logic                    v_line, h_line, v_on, h_on, stitch;
  logic                    unused_coord;

  // Scroll tick: one cycle pulse on the wrap of a 0..DELAY_COUNT-1 counter
  assign tick = (cnt == CNT_W'(DELAY_COUNT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

`ifdef HITOMEZASHI_LFSR_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form; nonzero seed keeps it out of the lock-up state
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       lfsr <= 16'hACE1;
    else if (tick) lfsr <= {lfsr_fb, lfsr[15:1]};
  end

  assign v_fill = lfsr[0];
  assign h_fill = lfsr[0];
`else
  assign v_fill = v_pat[V-1];
  assign h_fill = h_pat[H-1];
`endif

  // Load has priority over scroll for the selected pattern only
  always_comb begin
    v_nxt = v_pat;
    h_nxt = h_pat;
    if (i_load_valid && !i_load_sel) v_nxt = {v_pat[V-2:0], i_load_bit};
    else if (tick && i_mode[0])      v_nxt = {v_pat[V-2:0], v_fill};
    if (i_load_valid && i_load_sel)  h_nxt = {h_pat[H-2:0], i_load_bit};
    else if (tick && i_mode[1])      h_nxt = {h_pat[H-2:0], h_fill};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_pat <= V_SEED;
      h_pat <= H_SEED;
    end else begin
      v_pat <= v_nxt;
      h_pat <= h_nxt;
    end
  end

  // Grid decode on the two's-complement low bits, so negative coordinates wrap
  assign v_line = (i_x[CELL_LOG2-1:0] == '0);
  assign h_line = (i_y[CELL_LOG2-1:0] == '0);
  assign vidx   = i_x[CELL_LOG2 +: V_LINES_LOG2];
  assign hidx   = i_y[CELL_LOG2 +: H_LINES_LOG2];
  assign v_on   = i_y[CELL_LOG2] ^ v_pat[vidx];
  assign h_on   = i_x[CELL_LOG2] ^ h_pat[hidx];
  assign stitch = (v_line & v_on) | (h_line & h_on);

  assign unused_coord = ^{i_x, i_y};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      o_pix_valid <= 1'b0;
    end else begin
      {o_red, o_green, o_blue} <= stitch ? FG_RGB : BG_RGB;
      o_pix_valid              <= i_pix_valid;
    end
  end

endmodule

// File: tb/tb_hitomezashi_pattern_gen.sv
// Directed self-checking bench for hitomezashi_pattern_gen: reset, static decode, scroll, load, negative coords,
// and the scroll-fill sequence (LFSR when HITOMEZASHI_LFSR_EN is defined, rotation otherwise).
module tb_hitomezashi_pattern_gen;

  localparam logic [23:0] FG = 24'hFFFF00;
  localparam logic [23:0] BG = 24'h0000FF;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [15:0] x, y;
  logic               pix_valid;
  logic [1:0]         mode_a, mode_b;
  logic               load_valid_a, load_sel, load_bit;
  logic [7:0]         a_r, a_g, a_b, b_r, b_g, b_b;
  logic               a_valid, b_valid;
  logic [23:0]        a_rgb, b_rgb;

  int checks = 0;
  int errors = 0;

  assign a_rgb = {a_r, a_g, a_b};
  assign b_rgb = {b_r, b_g, b_b};

  always #5 CLK = ~CLK;

  hitomezashi_pattern_gen #(
    .V_SEED(64'h1), .H_SEED(32'h1), .DELAY_COUNT(4)
  ) dut_a (
    .CLK(CLK), .RST(RST), .i_x(x), .i_y(y), .i_pix_valid(pix_valid), .i_mode(mode_a),
    .i_load_valid(load_valid_a), .i_load_sel(load_sel), .i_load_bit(load_bit),
    .o_red(a_r), .o_green(a_g), .o_blue(a_b), .o_pix_valid(a_valid)
  );

  hitomezashi_pattern_gen #(
    .DELAY_COUNT(1)
  ) dut_b (
    .CLK(CLK), .RST(RST), .i_x(x), .i_y(y), .i_pix_valid(pix_valid), .i_mode(mode_b),
    .i_load_valid(1'b0), .i_load_sel(1'b0), .i_load_bit(1'b0),
    .o_red(b_r), .o_green(b_g), .o_blue(b_b), .o_pix_valid(b_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents a pixel, lets one active edge register it, returns at the next negedge
  task automatic query(input int xx, input int yy);
    x = 16'(xx);
    y = 16'(yy);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic [1:0] ma, input logic [1:0] mb);
    RST = 1'b1;
    @(negedge CLK);
    mode_a = ma;
    mode_b = mb;
    RST    = 1'b0;
  endtask

  initial begin
    logic [63:0] vm;
    logic [1:0]  cm;
    logic [15:0] rl;
    logic        fb;

    RST = 1'b1; x = '0; y = '0; pix_valid = 1'b0;
    mode_a = 2'b00; mode_b = 2'b00;
    load_valid_a = 1'b0; load_sel = 1'b0; load_bit = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reset asserted mid-stream clears outputs immediately and holds them
    pix_valid = 1'b1;
    query(0, 0);
    check("pre_reset_rgb", {8'h0, a_rgb}, {8'h0, FG});
    #2 RST = 1'b1;
    #1;
    check("reset_async_rgb_a", {8'h0, a_rgb}, 32'h0);
    check("reset_async_valid_a", {31'h0, a_valid}, 32'h0);
    check("reset_async_rgb_b", {8'h0, b_rgb}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("reset_hold_rgb", {8'h0, a_rgb}, 32'h0);
    check("reset_hold_valid", {31'h0, a_valid}, 32'h0);
    x = 16'sd1; y = 16'sd1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("post_reset_1_1", {8'h0, a_rgb}, {8'h0, BG});
    check("post_reset_valid", {31'h0, a_valid}, 32'h1);

    // Static decode, v_pat = 1, h_pat = 1
    query(0, 0);   check("static_0_0", {8'h0, a_rgb}, {8'h0, FG});
    query(0, 32);  check("static_0_32", {8'h0, a_rgb}, {8'h0, BG});
    query(5, 5);   check("static_5_5", {8'h0, a_rgb}, {8'h0, BG});
    query(32, 0);  check("static_32_0", {8'h0, a_rgb}, {8'h0, BG});
    query(64, 0);  check("static_64_0", {8'h0, a_rgb}, {8'h0, FG});
    pix_valid = 1'b0;
    query(0, 0);
    check("rgb_without_valid", {8'h0, a_rgb}, {8'h0, FG});
    check("valid_low", {31'h0, a_valid}, 32'h0);
    pix_valid = 1'b1;

    // Negative coordinates on the 5A5A.. seed
    query(-32, 0); check("neg_m32_0", {8'h0, b_rgb}, {8'h0, BG});
    query(-32, 1); check("neg_m32_1", {8'h0, b_rgb}, {8'h0, BG});
    query(-64, 1); check("neg_m64_1", {8'h0, b_rgb}, {8'h0, FG});

    // Scroll with DELAY_COUNT = 4: ticks on counter value 3; mode dropped to 0 before edge 13
    do_reset(2'b01, 2'b00);
    vm = 64'h1; cm = 2'd0;
    for (int k = 1; k <= 16; k++) begin
      int bitn;
      if (k == 13) mode_a = 2'b00;
      bitn = (k % 4);
      query(32 * bitn, 1);
      check($sformatf("scroll_k%0d_bit%0d", k, bitn), {8'h0, a_rgb}, {8'h0, vm[bitn] ? FG : BG});
      if (cm == 2'd3) begin
        if (mode_a[0]) vm = {vm[62:0], vm[63]};
        cm = 2'd0;
      end else begin
        cm = cm + 2'd1;
      end
    end

    // Full serial reload of v_pat with ones
    load_valid_a = 1'b1; load_sel = 1'b0; load_bit = 1'b1;
    repeat (64) @(posedge CLK);
    @(negedge CLK);
    load_valid_a = 1'b0;
    query(0, 1);       check("load_ones_bit0", {8'h0, a_rgb}, {8'h0, FG});
    query(32 * 31, 1); check("load_ones_bit31", {8'h0, a_rgb}, {8'h0, FG});
    query(-32, 1);     check("load_ones_bit63", {8'h0, a_rgb}, {8'h0, FG});

    // Load on the tick edge with mode 11: v_pat takes the load bit, h_pat still rotates
    do_reset(2'b11, 2'b00);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    load_valid_a = 1'b1; load_sel = 1'b0; load_bit = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    load_valid_a = 1'b0;
    mode_a = 2'b00;
    query(0, 1);  check("tickload_v0", {8'h0, a_rgb}, {8'h0, FG});
    query(32, 1); check("tickload_v1", {8'h0, a_rgb}, {8'h0, FG});
    query(64, 1); check("tickload_v2", {8'h0, a_rgb}, {8'h0, BG});
    query(1, 0);  check("tickload_h0", {8'h0, a_rgb}, {8'h0, BG});
    query(1, 32); check("tickload_h1", {8'h0, a_rgb}, {8'h0, FG});

    // Single-cycle h_pat load of a zero: h_pat 2 -> 4
    load_valid_a = 1'b1; load_sel = 1'b1; load_bit = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    load_valid_a = 1'b0;
    query(1, 32); check("hload_h1", {8'h0, a_rgb}, {8'h0, BG});
    query(1, 64); check("hload_h2", {8'h0, a_rgb}, {8'h0, FG});

    // Tick every cycle on dut_b: v_pat[0] follows the scroll fill source
    x = 16'sd0; y = 16'sd1;
    do_reset(2'b00, 2'b01);
    vm = 64'h5A5A_5A5A_5A5A_5A5A;
    rl = 16'hACE1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("fill_seq_k%0d", k), {8'h0, b_rgb}, {8'h0, vm[0] ? FG : BG});
`ifdef HITOMEZASHI_LFSR_EN
      vm = {vm[62:0], rl[0]};
      fb = rl[0] ^ rl[2] ^ rl[3] ^ rl[5];
      rl = {fb, rl[15:1]};
`else
      vm = {vm[62:0], vm[63]};
      fb = 1'b0;
      rl = rl;
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
